// File: rtl/step_arbiter_pkg.sv
// Shared constants and types for the step arbiter: lane numbering, lane count
// and the arbiter FSM state encoding.
package step_arbiter_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;

  localparam logic [LANE_W-1:0] LANE_LEFT  = 2'd0;
  localparam logic [LANE_W-1:0] LANE_DOWN  = 2'd1;
  localparam logic [LANE_W-1:0] LANE_UP    = 2'd2;
  localparam logic [LANE_W-1:0] LANE_RIGHT = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // Next lane in round-robin order, wrapping right -> left.
  function automatic logic [LANE_W-1:0] lane_inc(input logic [LANE_W-1:0] lane);
    return lane + LANE_W'(1);
  endfunction

endpackage

// File: rtl/step_arbiter_lane_pending.sv
// One pad lane: pending flag plus age counter, with drop and expiry pulses.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   armed           - low flushes the lane and ignores presses
//   press           - one-cycle press pulse for this lane
//   offered         - this lane is the one currently offered to the scorer
//   grant           - offered and accepted this cycle
//   pending         - registered pending flag
//   pending_nxt_c   - pending flag for next cycle (combinational)
//   age_nxt_c       - age for next cycle (combinational)
//   expiring_c      - lane is being discarded as stale at this edge
//   dropped/expired - registered one-cycle pulses
module step_arbiter_lane_pending #(
  parameter int unsigned AGE_W   = 4,
  parameter int unsigned MAX_AGE = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             armed,
  input  logic             press,
  input  logic             offered,
  input  logic             grant,
  output logic             pending,
  output logic             pending_nxt_c,
  output logic [AGE_W-1:0] age_nxt_c,
  output logic             expiring_c,
  output logic             dropped,
  output logic             expired
);

  localparam logic [AGE_W-1:0] AGE_SAT   = '1;
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_AGE);

  logic [AGE_W-1:0] age;
  logic             dropped_nxt;
  logic             expired_nxt;

  // The offered lane is frozen: it neither ages nor expires.
  assign expiring_c = pending && !offered && (age == AGE_LIMIT);

  // Next pending/age and pulse generation.
  always_comb begin
    pending_nxt_c = pending;
    age_nxt_c     = age;
    dropped_nxt   = 1'b0;
    expired_nxt   = 1'b0;
    if (armed) begin
      if (pending && !offered && (age != AGE_SAT)) begin
        age_nxt_c = age + AGE_W'(1);
      end
      if (expiring_c) begin
        pending_nxt_c = 1'b0;
        age_nxt_c     = '0;
        expired_nxt   = 1'b1;
      end
      if (grant) begin
        pending_nxt_c = 1'b0;
      end
      // A press landing on the entry being consumed replaces it instead of dropping.
      if (press) begin
        if (pending && !grant) begin
          dropped_nxt = 1'b1;
        end else begin
          pending_nxt_c = 1'b1;
          age_nxt_c     = '0;
        end
      end
    end else begin
      pending_nxt_c = 1'b0;
      age_nxt_c     = '0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      age     <= '0;
      dropped <= 1'b0;
      expired <= 1'b0;
    end else begin
      pending <= pending_nxt_c;
      age     <= age_nxt_c;
      dropped <= dropped_nxt;
      expired <= expired_nxt;
    end
  end

endmodule

// File: rtl/step_arbiter.sv
// Shares the step-scoring path among the four arrow pads: latches press pulses,
// ages and expires them, and offers them round-robin over valid/ready.
// Ports:
//   Clock, reset  - clock, synchronous active-high reset
//   armed         - game running; low flushes and ignores presses
//   press[3:0]    - one-cycle press pulses, bit i = lane i
//   req_ready     - scorer accepts the offered request
//   req_valid     - request offered
//   req_lane      - lane of offered request
//   req_age       - age of offered press, frozen at offer time
//   dropped[3:0]  - press lost on an already-pending lane
//   expired[3:0]  - pending press discarded as stale
//   busy          - any lane pending or request offered
module step_arbiter
  import step_arbiter_pkg::*;
#(
  parameter int unsigned AGE_W   = 4,
  parameter int unsigned MAX_AGE = 12
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 armed,
  input  logic [NUM_LANES-1:0] press,
  input  logic                 req_ready,
  output logic                 req_valid,
  output logic [LANE_W-1:0]    req_lane,
  output logic [AGE_W-1:0]     req_age,
  output logic [NUM_LANES-1:0] dropped,
  output logic [NUM_LANES-1:0] expired,
  output logic                 busy
);

  arb_state_e             state_q, state_nxt;
  logic [LANE_W-1:0]      rr_ptr, rr_nxt;
  logic                   req_valid_nxt;
  logic [LANE_W-1:0]      req_lane_nxt;
  logic [AGE_W-1:0]       req_age_nxt;
  logic                   busy_nxt;

  logic [NUM_LANES-1:0]   pending_q;
  logic [NUM_LANES-1:0]   pending_nxt;
  logic [NUM_LANES-1:0]   expiring;
  logic [NUM_LANES-1:0]   eligible;
  logic [NUM_LANES-1:0]   offered;
  logic [NUM_LANES-1:0]   grant;
  logic [AGE_W-1:0]       age_nxt [NUM_LANES];

  logic                   found;
  logic [LANE_W-1:0]      sel;
  logic [LANE_W-1:0]      idx;

  // Per-lane pending/age trackers.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign offered[i] = (state_q == OFFER) && (req_lane == LANE_W'(i));
    assign grant[i]   = offered[i] && req_ready;

    step_arbiter_lane_pending #(
      .AGE_W   (AGE_W),
      .MAX_AGE (MAX_AGE)
    ) u_lane (
      .clk           (Clock),
      .reset         (reset),
      .armed         (armed),
      .press         (press[i]),
      .offered       (offered[i]),
      .grant         (grant[i]),
      .pending       (pending_q[i]),
      .pending_nxt_c (pending_nxt[i]),
      .age_nxt_c     (age_nxt[i]),
      .expiring_c    (expiring[i]),
      .dropped       (dropped[i]),
      .expired       (expired[i])
    );
  end

  // Lanes discarded this cycle must not be offered.
  assign eligible = pending_q & ~expiring;

  // Arbiter next-state and registered-output values.
  always_comb begin
    state_nxt    = state_q;
    rr_nxt       = rr_ptr;
    req_lane_nxt = req_lane;
    req_age_nxt  = req_age;
    found        = 1'b0;
    sel          = '0;
    idx          = '0;

    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      idx = rr_ptr + LANE_W'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    if (armed) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_nxt    = OFFER;
            req_lane_nxt = sel;
            // Age as it stands once this edge's increment lands.
            req_age_nxt  = age_nxt[sel];
          end
        end
        OFFER: begin
          if (req_ready) begin
            state_nxt = IDLE;
            rr_nxt    = lane_inc(req_lane);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = IDLE;
    end

    req_valid_nxt = (state_nxt == OFFER);
    busy_nxt      = (|pending_nxt) || req_valid_nxt;
  end

  // Arbiter state and output registers.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= LANE_LEFT;
      req_valid <= 1'b0;
      req_lane  <= '0;
      req_age   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rr_ptr    <= rr_nxt;
      req_valid <= req_valid_nxt;
      req_lane  <= req_lane_nxt;
      req_age   <= req_age_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_step_arbiter.sv
// Self-checking bench for step_arbiter: hand-derived vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_step_arbiter;

  localparam int AGE_W   = 4;
  localparam int MAX_AGE = 12;
  localparam int AGE_SAT = (1 << AGE_W) - 1;

  logic             Clock = 1'b0;
  logic             reset = 1'b1;
  logic             armed = 1'b0;
  logic [3:0]       press = 4'b0000;
  logic             req_ready = 1'b0;
  logic             req_valid;
  logic [1:0]       req_lane;
  logic [AGE_W-1:0] req_age;
  logic [3:0]       dropped;
  logic [3:0]       expired;
  logic             busy;

  always #5 Clock = ~Clock;

  step_arbiter #(.AGE_W(AGE_W), .MAX_AGE(MAX_AGE)) dut (
    .Clock     (Clock),
    .reset     (reset),
    .armed     (armed),
    .press     (press),
    .req_ready (req_ready),
    .req_valid (req_valid),
    .req_lane  (req_lane),
    .req_age   (req_age),
    .dropped   (dropped),
    .expired   (expired),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, ages, current offer and round-robin start.
  bit       m_pend [4];
  int       m_age  [4];
  bit       m_off;
  int       m_lane;
  int       m_rage;
  int       m_rr;
  bit [3:0] m_drop;
  bit [3:0] m_exp;
  bit       m_busy;

  task automatic model_step();
    bit np [4];
    int na [4];
    bit ex [4];
    bit grant;
    int sel;
    m_drop = '0;
    m_exp  = '0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_age[i] = 0; end
      m_off = 0; m_lane = 0; m_rage = 0; m_rr = 0; m_busy = 0;
      return;
    end
    if (!armed) begin
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_age[i] = 0; end
      m_off = 0; m_busy = 0;
      return;
    end
    grant = m_off && req_ready;
    for (int i = 0; i < 4; i++)
      ex[i] = m_pend[i] && !(m_off && m_lane == i) && (m_age[i] == MAX_AGE);
    sel = -1;
    if (!m_off) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (sel < 0 && m_pend[j] && !ex[j]) sel = j;
      end
    end
    for (int i = 0; i < 4; i++) begin
      np[i] = m_pend[i];
      na[i] = m_age[i];
      if (m_pend[i] && !(m_off && m_lane == i)) na[i] = (m_age[i] + 1 > AGE_SAT) ? AGE_SAT : m_age[i] + 1;
      if (ex[i]) begin np[i] = 0; na[i] = 0; m_exp[i] = 1'b1; end
      if (grant && m_lane == i) np[i] = 0;
      if (press[i]) begin
        if (m_pend[i] && !(grant && m_lane == i)) m_drop[i] = 1'b1;
        else begin np[i] = 1; na[i] = 0; end
      end
    end
    if (m_off) begin
      if (req_ready) begin m_off = 0; m_rr = (m_lane + 1) % 4; end
    end else if (sel >= 0) begin
      m_off = 1; m_lane = sel; m_rage = na[sel];
    end
    m_busy = m_off;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = np[i];
      m_age[i]  = na[i];
      if (np[i]) m_busy = 1;
    end
  endtask

  task automatic compare_model();
    check("model req_valid", int'(req_valid), int'(m_off));
    if (m_off) begin
      check("model req_lane", int'(req_lane), m_lane);
      check("model req_age", int'(req_age), m_rage);
    end
    check("model dropped", int'(dropped), int'(m_drop));
    check("model expired", int'(expired), int'(m_exp));
    check("model busy", int'(busy), int'(m_busy));
  endtask

  // One clock: model and DUT both consume the inputs at the edge; compare after.
  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    bit       rst;
    bit       arm;
    bit [3:0] prs;
    bit       rdy;
    bit       v;
    int       lane;
    int       age;
    bit [3:0] drp;
    bit [3:0] ex;
    bit       bsy;
  } vec_t;

  vec_t tbl [8];
  int   glane [4];
  int   gcyc  [4];
  int   ng;
  int   exp_at;
  bit   saw3;
  int   rdy_pct;

  initial begin
    // Single press, then a second press on a pending lane.
    tbl[0] = '{1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0};
    tbl[1] = '{0, 1, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000, 1};
    tbl[2] = '{0, 1, 4'b0000, 1, 1, 0, 1, 4'b0000, 4'b0000, 1};
    tbl[3] = '{0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0};
    tbl[4] = '{0, 1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 1};
    tbl[5] = '{0, 1, 4'b0010, 0, 1, 1, 1, 4'b0010, 4'b0000, 1};
    tbl[6] = '{0, 1, 4'b0000, 0, 1, 1, 1, 4'b0000, 4'b0000, 1};
    tbl[7] = '{0, 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0};

    for (int r = 0; r < 8; r++) begin
      reset = tbl[r].rst; armed = tbl[r].arm; press = tbl[r].prs; req_ready = tbl[r].rdy;
      tick();
      check($sformatf("vec%0d req_valid", r), int'(req_valid), int'(tbl[r].v));
      if (tbl[r].v) begin
        check($sformatf("vec%0d req_lane", r), int'(req_lane), tbl[r].lane);
        check($sformatf("vec%0d req_age", r), int'(req_age), tbl[r].age);
      end
      check($sformatf("vec%0d dropped", r), int'(dropped), int'(tbl[r].drp));
      check($sformatf("vec%0d expired", r), int'(expired), int'(tbl[r].ex));
      check($sformatf("vec%0d busy", r), int'(busy), int'(tbl[r].bsy));
    end

    // All four lanes at once, twice: order 0,1,2,3 two cycles apart each time.
    reset = 1; press = 0; tick(); reset = 0; armed = 1; req_ready = 1;
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < 4; i++) begin glane[i] = -1; gcyc[i] = -100; end
      ng = 0;
      press = 4'b1111; tick(); press = 4'b0000;
      for (int c = 0; c < 12; c++) begin
        if (req_valid && req_ready && ng < 4) begin glane[ng] = int'(req_lane); gcyc[ng] = c; ng++; end
        tick();
      end
      for (int i = 0; i < 4; i++) check($sformatf("rr run%0d grant%0d lane", run, i), glane[i], i);
      for (int i = 1; i < 4; i++) check($sformatf("rr run%0d spacing%0d", run, i), gcyc[i] - gcyc[i-1], 2);
    end

    // Backpressure: offer held with constant age, no expiry.
    req_ready = 0; press = 4'b0100; tick(); press = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp held valid", int'(req_valid), 1);
      check("bp held lane", int'(req_lane), 2);
      check("bp held age", int'(req_age), 1);
    end
    req_ready = 1; tick();
    check("bp grant valid", int'(req_valid), 0);
    check("bp grant busy", int'(busy), 0);

    // Expiry: lane 3 ages out while lane 0 is stuck in offer.
    req_ready = 0; press = 4'b0001; tick(); press = 0; tick();
    press = 4'b1000; tick(); press = 0;
    exp_at = -1; saw3 = 0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (expired[3] && exp_at < 0) exp_at = k;
      if (req_valid && req_lane == 2'd3) saw3 = 1;
    end
    check("expiry cycle", exp_at, MAX_AGE + 2);
    req_ready = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (req_valid && req_lane == 2'd3) saw3 = 1;
    end
    check("expired lane never offered", int'(saw3), 0);
    check("expiry busy", int'(busy), 0);

    // Grant/press collision on lane 1.
    req_ready = 0; press = 4'b0010; tick(); press = 0; tick();
    check("coll offer lane", int'(req_lane), 1);
    press = 4'b0010; req_ready = 1; tick(); press = 0;
    check("coll dropped", int'(dropped), 0);
    check("coll busy", int'(busy), 1);
    check("coll valid gap", int'(req_valid), 0);
    tick();
    check("coll reoffer valid", int'(req_valid), 1);
    check("coll reoffer lane", int'(req_lane), 1);
    check("coll reoffer age", int'(req_age), 1);
    tick();

    // Flush mid-offer, presses ignored while disarmed.
    req_ready = 0; press = 4'b0111; tick(); press = 0; tick();
    check("flush pre valid", int'(req_valid), 1);
    armed = 0; tick();
    check("flush valid", int'(req_valid), 0);
    check("flush busy", int'(busy), 0);
    check("flush pulses", int'(dropped | expired), 0);
    press = 4'b1111; tick(); press = 0;
    check("disarmed press busy", int'(busy), 0);
    armed = 1; tick();
    check("rearm busy", int'(busy), 0);
    check("rearm valid", int'(req_valid), 0);

    // Reset mid-offer.
    press = 4'b0001; tick(); press = 0; tick();
    reset = 1; tick(); reset = 0;
    check("rst valid", int'(req_valid), 0);
    check("rst lane", int'(req_lane), 0);
    check("rst age", int'(req_age), 0);
    check("rst pulses", int'(dropped | expired), 0);
    check("rst busy", int'(busy), 0);

    // Randomized traffic against the model.
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_pct = (c % 600 == 0) ? 5 : ((c % 600 == 200) ? 35 : 90);
      reset     = ($urandom_range(0, 299) == 0);
      armed     = ($urandom_range(0, 59) != 0);
      press     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_ready = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_arbiter.md
Name: step_arbiter

Overview:
- Shares the single downstream step-scoring path among the four arrow pads (0=left, 1=down, 2=up, 3=right).
- Each pad's one-cycle press pulse (from its press-conditioning FSM) is latched as a pending request.
- Pending requests are aged, expired when stale, and granted round-robin over a valid/ready handshake to the scorer.
- Sits between the four pad conditioners and the scoring/judgement block.

Parameters:
- AGE_W, 4, width of per-lane age counters and of req_age.
- MAX_AGE, 12, age at which a non-offered pending press is discarded as stale; must be ≤ 2^AGE_W-1.

Ports:
- Clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- armed  in  1  game running; low flushes and ignores all presses.
- press  in  4  one-cycle press pulses, bit i = lane i.
- req_ready  in  1  scorer accepts the offered request this cycle.
- req_valid  out  1  request offered to scorer.
- req_lane  out  2  lane of offered request.
- req_age  out  AGE_W  age of offered press, frozen at offer time.
- dropped  out  4  one-cycle pulse: press lost because its lane was already pending.
- expired  out  4  one-cycle pulse: pending press discarded at MAX_AGE.
- busy  out  1  any lane pending or request offered.

Behaviour:
- Interface: one clock (Clock); reset is synchronous and active-high.
- Reset: pending=0, ages=0, rr_ptr=0, state IDLE; req_valid, req_lane, req_age, dropped, expired, busy all 0.
- Latch: press[i] with armed=1 sets pending[i] and age[i]=0 next cycle.
- Press on an already-pending lane: pending unchanged, age not restarted, dropped[i] pulses next cycle.
- Exception: same lane pressed while it is being granted (OFFER and req_ready) → consumed entry cleared, new press becomes pending with age 0, no drop.
- Aging: each cycle every pending lane not currently offered does age+1, saturating at 2^AGE_W-1.
- Expiry: non-offered lane reaching age==MAX_AGE → pending cleared and expired[i] pulses next cycle. The offered lane never expires.
- FSM states IDLE and OFFER:
  - IDLE: if any pending, select first pending lane searching rr_ptr, rr_ptr+1, ... mod 4. Lanes that expire this same cycle are ineligible. Next cycle OFFER with req_valid=1, req_lane=sel, req_age=age[sel].
  - OFFER: req_valid, req_lane and req_age held stable until req_ready. On req_ready: pending[lane] cleared, rr_ptr=lane+1 mod 4, next state IDLE (req_valid=0 next cycle).
  - Throughput: at most one grant per 2 cycles. Press-to-req_valid latency is 2 cycles minimum.
- armed low (any state): next cycle pending=0, ages=0, state IDLE, req_valid=0. rr_ptr retained. No dropped/expired pulses; presses ignored while low.
- An offer withdrawn by armed going low is allowed; the scorer ignores req_valid falling without ready.
- reset overrides armed and everything else.
- busy = |pending | req_valid, registered.

Decomposition:
- Shared package holds lane constants (LANE_LEFT..LANE_RIGHT), NUM_LANES=4, FSM state encodings (IDLE, OFFER).
- One natural sub-module: lane_pending, instantiated 4×. It holds the pending bit and age counter and produces the dropped/expired pulses.
- Arbiter FSM and rr pointer stay in the top.

Test Plan:
- Single press: reset, armed=1, press=0001 at t0, req_ready=1 → req_valid=1 at t0+2, lane 0, req_age=1; pending clear, busy=0 at t0+4.
- Simultaneous presses: press=1111 once, req_ready=1 → grants in order lanes 0,1,2,3, each 2 cycles apart. Repeat with press=1111 → order 0,1,2,3 again (rr_ptr wrapped to 0).
- Backpressure: press=0100, req_ready=0 for 20 cycles → req_valid held, lane 2, age constant, no expired. Then ready=1 → grant, busy falls.
- Expiry and drop:
  - Lane 3 pending while lane 0 is held in OFFER with ready=0 → expired[3] pulses after MAX_AGE=12 cycles of aging, and lane 3 is never granted.
  - Second press on pending lane 1 → dropped[1] pulse.
- Grant/press collision: in OFFER on lane 1, assert press[1] with req_ready → no drop, lane 1 is re-offered later with age restarted from 0.
- Flush: three lanes pending, deassert armed mid-OFFER → next cycle req_valid=0, busy=0, no pulses. Presses while armed=0 are ignored. reset mid-OFFER → all outputs 0.
